// File: rtl/ifetch_pkg.sv
// rtl/ifetch_pkg.sv - shared state encoding and constants for the instruction fetch stage
package ifetch_pkg;

  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_FAULT = 3'd4
  } ifetch_state_t;

  localparam logic [31:0] INST_NOP         = 32'h0000_0013;
  localparam logic [31:0] PC_STEP          = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/ifetch_pc_gen.sv
// rtl/ifetch_pc_gen.sv - next-PC mux and misalign flag; IFETCH_MISALIGN_TRAP_EN keeps raw redirect targets
module ifetch_pc_gen
  import ifetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        advance,
  output logic [31:0] next_pc,
  output logic        misalign
);

  logic [31:0] target;

  // Redirect wins over sequential advance; otherwise the PC holds.
  always_comb begin
    misalign = redirect_valid && (redirect_pc[1:0] != 2'b00);
`ifdef IFETCH_MISALIGN_TRAP_EN
    // The faulting target is kept as-is so it can be reported by the trap handler.
    target = redirect_pc;
`else
    target = {redirect_pc[31:2], 2'b00};
`endif
    if (redirect_valid) begin
      next_pc = target;
    end else if (advance) begin
      next_pc = pc + PC_STEP;
    end else begin
      next_pc = pc;
    end
  end

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - RV32I fetch stage FSM; IFETCH_MISALIGN_TRAP_EN enables the misaligned-redirect trap
module inst_fetch
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_fault
);

  ifetch_state_t state_q;
  ifetch_state_t state_d;
  logic [31:0]   pc_q;
  logic [31:0]   pc_d;
  logic          redirect_en;
  logic          advance;
  logic          capture;
  logic          misalign;

  // Once trapped, redirects no longer move the PC.
  assign redirect_en = redirect_valid && (state_q != S_FAULT);
  assign advance     = (state_q == S_HOLD) && inst_ready;
  assign capture     = (state_q == S_WAIT) && imem_rvalid && !redirect_valid;

  ifetch_pc_gen u_pc_gen (
    .pc             (pc_q),
    .redirect_valid (redirect_en),
    .redirect_pc    (redirect_pc),
    .advance        (advance),
    .next_pc        (pc_d),
    .misalign       (misalign)
  );

  // All outputs decode registered state only; no input reaches an output combinationally.
  assign imem_req   = (state_q == S_REQ);
  assign imem_addr  = {pc_q[31:2], 2'b00};
  assign inst_valid = (state_q == S_HOLD);

`ifdef IFETCH_MISALIGN_TRAP_EN
  assign fetch_fault = (state_q == S_FAULT);
`else
  logic misalign_unused;
  assign misalign_unused = misalign;
  assign fetch_fault     = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; redirect takes priority over memory and decode events.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        // The request goes out this cycle regardless, so a redirect must drain it.
        state_d = redirect_valid ? S_DRAIN : S_WAIT;
      end
      S_WAIT: begin
        if (redirect_valid) begin
          state_d = imem_rvalid ? S_REQ : S_DRAIN;
        end else if (imem_rvalid) begin
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_valid || inst_ready) begin
          state_d = S_REQ;
        end
      end
      S_DRAIN: begin
        // A redirect here only retargets the PC; the stale response still has to arrive.
        if (imem_rvalid) begin
          state_d = S_REQ;
        end
      end
      S_FAULT: begin
        state_d = S_FAULT;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
`ifdef IFETCH_MISALIGN_TRAP_EN
    if (redirect_en && misalign) begin
      state_d = S_FAULT;
    end
`endif
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  // Instruction/PC capture for decode; held stable until the next capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      inst   <= INST_NOP;
      pc_out <= 32'h0000_0000;
    end else if (capture) begin
      inst   <= imem_rdata;
      pc_out <= pc_q;
    end
  end

endmodule
